reset_sequencer: RTL and testbench



---
 rtl/reset_sequencer.sv | 167 ++++++++++++++++
 tb/tb_reset_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Board-level reset sequencer: synchronises global reset and PLL lock, stretches
// reset, then releases NUM_DOMAINS active-high domain resets one at a time.
module reset_sequencer #(
  parameter string FPGA_FAMILY    = "Xilinx",
  parameter int    NUM_DOMAINS    = 3,
  parameter int    STRETCH_CYCLES = 16,
  parameter int    GAP_CYCLES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   soft_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   all_released,
  output logic [2:0]             seq_state
);

  localparam int SYNC_STAGES = (FPGA_FAMILY == "Xilinx") ? 2 : 3;
  localparam int CNT_MAX     = (STRETCH_CYCLES > GAP_CYCLES) ? STRETCH_CYCLES : GAP_CYCLES;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);
  localparam int IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [NUM_DOMAINS-1:0] DOM_ONE = NUM_DOMAINS'(1'b1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STRETCH   = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] rst_chain_r;
  logic [SYNC_STAGES-1:0] lock_chain_r;
  logic                   rst_sync_s;
  logic                   lock_sync_s;
  logic                   in_seq_s;

  state_t                 state_r, state_n;
  logic [CNT_W-1:0]       cnt_r, cnt_n;
  logic [IDX_W-1:0]       idx_r, idx_n;
  logic [NUM_DOMAINS-1:0] rst_out_r, rst_out_n;
  logic                   all_rel_r, all_rel_n;

  // Synchroniser chains for reset deassertion and PLL lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_chain_r  <= '1;
      lock_chain_r <= '0;
    end else begin
      rst_chain_r  <= {rst_chain_r[SYNC_STAGES-2:0], 1'b0};
      lock_chain_r <= {lock_chain_r[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign rst_sync_s  = rst_chain_r[SYNC_STAGES-1];
  assign lock_sync_s = lock_chain_r[SYNC_STAGES-1];
  assign in_seq_s    = (state_r == STRETCH) || (state_r == RELEASE) || (state_r == RUN);

  // Next-state, counter, domain index and output computation.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    idx_n     = idx_r;
    rst_out_n = rst_out_r;
    all_rel_n = all_rel_r;
    if (in_seq_s && !lock_sync_s) begin
      // Lock loss outranks everything, including a pending soft request.
      state_n   = WAIT_LOCK;
      cnt_n     = '0;
      idx_n     = '0;
      rst_out_n = '1;
      all_rel_n = 1'b0;
    end else begin
      case (state_r)
        HOLD: begin
          cnt_n     = '0;
          idx_n     = '0;
          rst_out_n = '1;
          all_rel_n = 1'b0;
          if (!rst_sync_s) begin
            state_n = WAIT_LOCK;
          end else begin
            state_n = HOLD;
          end
        end
        WAIT_LOCK: begin
          if (lock_sync_s) begin
            state_n = STRETCH;
            cnt_n   = '0;
          end else begin
            state_n = WAIT_LOCK;
          end
        end
        STRETCH: begin
          if (cnt_r == CNT_W'(STRETCH_CYCLES - 1)) begin
            rst_out_n = rst_out_r & ~DOM_ONE;
            cnt_n     = '0;
            if (NUM_DOMAINS == 1) begin
              state_n   = RUN;
              idx_n     = '0;
              all_rel_n = 1'b1;
            end else begin
              state_n   = RELEASE;
              idx_n     = IDX_W'(1);
            end
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end
        RELEASE: begin
          if (cnt_r == CNT_W'(GAP_CYCLES - 1)) begin
            rst_out_n = rst_out_r & ~(DOM_ONE << idx_r);
            cnt_n     = '0;
            if (idx_r == IDX_W'(NUM_DOMAINS - 1)) begin
              state_n   = RUN;
              all_rel_n = 1'b1;
            end else begin
              idx_n = idx_r + IDX_W'(1);
            end
          end else begin
            cnt_n = cnt_r + CNT_W'(1);
          end
        end
        RUN: begin
          if (soft_rst_req) begin
            state_n   = STRETCH;
            cnt_n     = '0;
            idx_n     = '0;
            rst_out_n = '1;
            all_rel_n = 1'b0;
          end else begin
            state_n = RUN;
          end
        end
        default: begin
          state_n   = HOLD;
          cnt_n     = '0;
          idx_n     = '0;
          rst_out_n = '1;
          all_rel_n = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= HOLD;
      cnt_r     <= '0;
      idx_r     <= '0;
      rst_out_r <= '1;
      all_rel_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      idx_r     <= idx_n;
      rst_out_r <= rst_out_n;
      all_rel_r <= all_rel_n;
    end
  end

  assign rst_out      = rst_out_r;
  assign all_released = all_rel_r;
  assign seq_state    = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: a Xilinx/3-domain build and an
// Intel/1-domain build run side by side against a timeline-based reference model.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       soft_rst_req;
  logic [2:0] x_rst_out;
  logic       x_all;
  logic [2:0] x_state;
  logic [0:0] i_rst_out;
  logic       i_all;
  logic [2:0] i_state;

  int checks = 0;
  int errors = 0;
  int e      = 0;

  always #5 clk = ~clk;

  reset_sequencer dut_x (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .rst_out(x_rst_out), .all_released(x_all), .seq_state(x_state)
  );

  reset_sequencer #(
    .FPGA_FAMILY("Intel"), .NUM_DOMAINS(1), .STRETCH_CYCLES(8), .GAP_CYCLES(4)
  ) dut_i (
    .clk(clk), .rst(rst), .pll_locked(pll_locked), .soft_rst_req(soft_rst_req),
    .rst_out(i_rst_out), .all_released(i_all), .seq_state(i_state)
  );

  // Per-instance build parameters (0 = Xilinx build, 1 = Intel build).
  function automatic int p_sync(int p); return (p == 0) ? 2 : 3; endfunction
  function automatic int p_n(int p);    return (p == 0) ? 3 : 1; endfunction
  function automatic int p_st(int p);   return (p == 0) ? 16 : 8; endfunction
  function automatic int p_gap(int p);  return 4; endfunction

  // Model: edges since reset release, recent pll samples, mode (0 hold,
  // 1 waiting for lock, 2 sequencing) and edges since sequence start.
  int         m_nedge[2];
  logic [3:0] m_samp[2];
  int         m_mode[2];
  int         m_t[2];

  function automatic bit lock_sync_f(int p);
    return (m_nedge[p] >= p_sync(p)) && m_samp[p][p_sync(p)-1];
  endfunction

  function automatic int released_f(int p);
    int k;
    if (m_mode[p] != 2 || m_t[p] < p_st(p)) return 0;
    k = 1 + (m_t[p] - p_st(p)) / p_gap(p);
    return (k > p_n(p)) ? p_n(p) : k;
  endfunction

  function automatic int exp_state_f(int p);
    int k;
    if (m_mode[p] == 0) return 0;
    if (m_mode[p] == 1) return 1;
    k = released_f(p);
    if (k == 0) return 2;
    return (k < p_n(p)) ? 3 : 4;
  endfunction

  function automatic int exp_rst_f(int p);
    int r = 0;
    int k = released_f(p);
    for (int i = 0; i < p_n(p); i++) if (i >= k) r = r | (1 << i);
    return r;
  endfunction

  function automatic int exp_all_f(int p);
    return (m_mode[p] == 2 && released_f(p) == p_n(p)) ? 1 : 0;
  endfunction

  function automatic int dut_state(int p); return (p == 0) ? int'(x_state) : int'(i_state); endfunction
  function automatic int dut_rst(int p);   return (p == 0) ? int'(x_rst_out) : int'(i_rst_out); endfunction
  function automatic int dut_all(int p);   return (p == 0) ? int'(x_all) : int'(i_all); endfunction

  // Reference model update on each clock edge / asynchronous reset.
  always @(posedge clk or posedge rst) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        m_nedge[p] <= 0;
        m_samp[p]  <= 4'b0000;
        m_mode[p]  <= 0;
        m_t[p]     <= 0;
      end else begin
        case (m_mode[p])
          0: if (m_nedge[p] >= p_sync(p)) m_mode[p] <= 1;
          1: if (lock_sync_f(p)) begin m_mode[p] <= 2; m_t[p] <= 0; end
          default: begin
            if (!lock_sync_f(p)) m_mode[p] <= 1;
            else if (exp_state_f(p) == 4 && soft_rst_req) m_t[p] <= 0;
            else if (m_t[p] < 1000) m_t[p] <= m_t[p] + 1;
          end
        endcase
        m_nedge[p] <= (m_nedge[p] < 100) ? m_nedge[p] + 1 : 100;
        m_samp[p]  <= {m_samp[p][2:0], pll_locked};
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Hand-computed expectations applied to both the DUT and the model.
  task automatic lit(input string nm, input int p, input int st, input int ro, input int al);
    chk({nm, "_dut_state"}, dut_state(p), st);
    chk({nm, "_dut_rst_out"}, dut_rst(p), ro);
    chk({nm, "_dut_all"}, dut_all(p), al);
    chk({nm, "_model_state"}, exp_state_f(p), st);
    chk({nm, "_model_rst_out"}, exp_rst_f(p), ro);
    chk({nm, "_model_all"}, exp_all_f(p), al);
  endtask

  // Cycle-by-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      chk((p == 0) ? "cmp_x_state" : "cmp_i_state", dut_state(p), exp_state_f(p));
      chk((p == 0) ? "cmp_x_rst_out" : "cmp_i_rst_out", dut_rst(p), exp_rst_f(p));
      chk((p == 0) ? "cmp_x_all" : "cmp_i_all", dut_all(p), exp_all_f(p));
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
    e++;
  endtask

  // Called just after rst is released: edge numbering restarts at 1.
  task automatic run_power_on(input string nm);
    e = 0;
    repeat (30) begin
      tick();
      if (e == 2)  lit({nm, "_x_e2"}, 0, 0, 7, 0);
      if (e == 3)  lit({nm, "_x_e3"}, 0, 1, 7, 0);
      if (e == 4)  lit({nm, "_x_e4"}, 0, 2, 7, 0);
      if (e == 19) lit({nm, "_x_e19"}, 0, 2, 7, 0);
      if (e == 20) lit({nm, "_x_e20"}, 0, 3, 6, 0);
      if (e == 23) lit({nm, "_x_e23"}, 0, 3, 6, 0);
      if (e == 24) lit({nm, "_x_e24"}, 0, 3, 4, 0);
      if (e == 27) lit({nm, "_x_e27"}, 0, 3, 4, 0);
      if (e == 28) lit({nm, "_x_e28"}, 0, 4, 0, 1);
      if (e == 3)  lit({nm, "_i_e3"}, 1, 0, 1, 0);
      if (e == 4)  lit({nm, "_i_e4"}, 1, 1, 1, 0);
      if (e == 5)  lit({nm, "_i_e5"}, 1, 2, 1, 0);
      if (e == 12) lit({nm, "_i_e12"}, 1, 2, 1, 0);
      if (e == 13) lit({nm, "_i_e13"}, 1, 4, 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    pll_locked = 1'b1;
    soft_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    lit("reset_x", 0, 0, 7, 0);
    lit("reset_i", 1, 0, 1, 0);

    // Power-on with lock present throughout.
    rst = 1'b0;
    run_power_on("pwr");

    // Soft reset pulse in RUN, then an ignored pulse during STRETCH.
    while (e < 40) tick();
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    lit("soft_x_e41", 0, 2, 7, 0);
    lit("soft_i_e41", 1, 2, 1, 0);
    while (e < 45) tick();
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    lit("soft_ign_x_e46", 0, 2, 7, 0);
    while (e < 48) tick();
    lit("soft_i_e48", 1, 2, 1, 0);
    tick();
    lit("soft_i_e49", 1, 4, 0, 1);
    while (e < 56) tick();
    lit("soft_x_e56", 0, 2, 7, 0);
    tick();
    lit("soft_x_e57", 0, 3, 6, 0);
    while (e < 64) tick();
    lit("soft_x_e64", 0, 3, 4, 0);
    tick();
    lit("soft_x_e65", 0, 4, 0, 1);

    // Late lock: pll low until sampled high at edge 30.
    rst = 1'b1;
    pll_locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e = 0;
    while (e < 29) tick();
    lit("late_x_e29", 0, 1, 7, 0);
    lit("late_i_e29", 1, 1, 1, 0);
    pll_locked = 1'b1;
    tick(); tick();
    lit("late_x_e31", 0, 1, 7, 0);
    tick();
    lit("late_x_e32", 0, 2, 7, 0);
    lit("late_i_e32", 1, 1, 1, 0);
    tick();
    lit("late_i_e33", 1, 2, 1, 0);
    while (e < 47) tick();
    lit("late_x_e47", 0, 2, 7, 0);
    tick();
    lit("late_x_e48", 0, 3, 6, 0);
    while (e < 56) tick();
    lit("late_x_e56", 0, 4, 0, 1);

    // Lock loss during RELEASE, then recovery.
    while (e < 60) tick();
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    while (e < 78) tick();
    lit("loss_x_e78", 0, 3, 6, 0);
    pll_locked = 1'b0;
    tick(); tick();
    lit("loss_x_e80", 0, 3, 6, 0);
    tick();
    lit("loss_x_e81", 0, 1, 7, 0);
    while (e < 85) tick();
    pll_locked = 1'b1;
    tick(); tick();
    lit("relock_x_e87", 0, 1, 7, 0);
    tick();
    lit("relock_x_e88", 0, 2, 7, 0);
    while (e < 104) tick();
    lit("relock_x_e104", 0, 3, 6, 0);
    while (e < 112) tick();
    lit("relock_x_e112", 0, 4, 0, 1);

    // Asynchronous rst mid-STRETCH with no clock edge, then power-on replay.
    while (e < 115) tick();
    soft_rst_req = 1'b1; tick(); soft_rst_req = 1'b0;
    while (e < 120) tick();
    lit("stretch_x_e120", 0, 2, 7, 0);
    #2 rst = 1'b1;
    #1;
    lit("async_x", 0, 0, 7, 0);
    lit("async_i", 1, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_power_on("replay");

    // Randomised lock drops, soft pulses and asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if (pll_locked && $urandom_range(0, 999) < 8) pll_locked = 1'b0;
      else if (!pll_locked && $urandom_range(0, 999) < 60) pll_locked = 1'b1;
      soft_rst_req = ($urandom_range(0, 999) < 30) ? 1'b1 : 1'b0;
      tick();
      if ($urandom_range(0, 999) < 3) begin
        #2 rst = 1'b1;
        #1;
        lit("rand_async_x", 0, 0, 7, 0);
        lit("rand_async_i", 1, 0, 1, 0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
